// File: rtl/relu_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : relu_sched_pkg
// Purpose  : Shared types and constants for the ReLU scheduler slice.
//            - RELU_LAT    : pipeline depth of the shared activation unit
//            - relu_state_e: scheduler FSM states
//            - relu_sb_t   : sideband carried alongside each in-flight word
// Build    : RELU_SCHED_BYPASS_EN adds the per-word bypass bit to the sideband.
// Revision : 1.0 - initial release
// ============================================================================
package relu_sched_pkg;

    // Cycles from X/X_VLD capture to Y/Y_VLD in the activation unit.
    localparam int RELU_LAT = 2;

    // The sideband channel field is sized for the largest supported NUM_CH;
    // the top truncates it to CH_W on the way out.
    localparam int SB_CH_W = 8;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } relu_state_e;

    typedef struct packed {
        logic [SB_CH_W-1:0] ch;
        logic               last;
`ifdef RELU_SCHED_BYPASS_EN
        logic               byp;
`endif
        logic               vld;
    } relu_sb_t;

endpackage : relu_sched_pkg
`default_nettype wire

// File: rtl/relu_rr_arb.sv
`default_nettype none
// ============================================================================
// Module   : relu_rr_arb
// Purpose  : Combinational round-robin pick. Searches req_vld_i starting at
//            ptr_i+1 and wrapping, so the channel served last has the lowest
//            priority.
// Ports    : req_vld_i [NUM_CH]  request vector
//            ptr_i     [CH_W]    channel served last
//            idx_o     [CH_W]    selected channel (0 when none found)
//            found_o             at least one request present
// Revision : 1.0 - initial release
// ============================================================================
module relu_rr_arb #(
    parameter int NUM_CH = 4,
    parameter int CH_W   = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req_vld_i,
    input  logic [CH_W-1:0]   ptr_i,
    output logic [CH_W-1:0]   idx_o,
    output logic              found_o
);

    logic [CH_W-1:0] cand;

    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        cand    = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            cand = CH_W'((int'(ptr_i) + k) % NUM_CH);
            if (!found_o && req_vld_i[cand]) begin
                found_o = 1'b1;
                idx_o   = cand;
            end
        end
    end

endmodule : relu_rr_arb
`default_nettype wire

// File: rtl/relu_sched.sv
`default_nettype none
// ============================================================================
// Module   : relu_sched
// Purpose  : Round-robin scheduler sharing one ReLU activation unit among
//            NUM_CH channels. Grants one channel at a time in bursts of up to
//            BURST words, tracks {ch, last, byp} through the unit's pipeline
//            and re-tags the results onto a single valid/ready stream.
// Build    : RELU_SCHED_BYPASS_EN - adds REQ_BYP; bypass words return the
//            unit's PASSTHRU (raw X) instead of the rectified value.
// Ports    : CLK, RESET (sync, active-high)
//            REQ_DATA/REQ_VLD/REQ_LAST[/REQ_BYP] in, REQ_RDY out  - channels
//            RELU_EN/RELU_X/RELU_X_VLD out, RELU_Y/RELU_Y_VLD/RELU_PASSTHRU in
//            OUT_DATA/OUT_VLD/OUT_CH/OUT_LAST out, OUT_RDY in  - result stream
//            DRAINED out - idle with nothing in flight
// Revision : 1.0 - initial release
// ============================================================================
module relu_sched
    import relu_sched_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int INWIDTH = 16,
    parameter int BURST   = 8,
    localparam int CH_W   = $clog2(NUM_CH)
) (
    input  logic                        CLK,
    input  logic                        RESET,
    input  logic [NUM_CH*INWIDTH-1:0]   REQ_DATA,
    input  logic [NUM_CH-1:0]           REQ_VLD,
    input  logic [NUM_CH-1:0]           REQ_LAST,
`ifdef RELU_SCHED_BYPASS_EN
    input  logic [NUM_CH-1:0]           REQ_BYP,
`endif
    output logic [NUM_CH-1:0]           REQ_RDY,
    output logic                        RELU_EN,
    output logic [INWIDTH-1:0]          RELU_X,
    output logic                        RELU_X_VLD,
    input  logic [INWIDTH-1:0]          RELU_Y,
    input  logic                        RELU_Y_VLD,
    input  logic [INWIDTH-1:0]          RELU_PASSTHRU,
    output logic [INWIDTH-1:0]          OUT_DATA,
    output logic                        OUT_VLD,
    input  logic                        OUT_RDY,
    output logic [CH_W-1:0]             OUT_CH,
    output logic                        OUT_LAST,
    output logic                        DRAINED
);

    localparam int CNT_W = (BURST > 1) ? $clog2(BURST) : 1;

    relu_state_e        state_q;
    logic [CH_W-1:0]    ptr_q;
    logic [CH_W-1:0]    gnt_q;
    logic [CNT_W-1:0]   cnt_q;
    relu_sb_t           sb_q [RELU_LAT];
    relu_sb_t           sb_d;
    relu_sb_t           sb_out;

    logic [INWIDTH-1:0] req_word [NUM_CH];
    logic [CH_W-1:0]    arb_idx;
    logic               arb_found;
    logic               in_grant;
    logic               xfer;
    logic               burst_end;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_unpack
        assign req_word[i] = REQ_DATA[i*INWIDTH +: INWIDTH];
    end

    relu_rr_arb #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_arb (
        .req_vld_i (REQ_VLD),
        .ptr_i     (ptr_q),
        .idx_o     (arb_idx),
        .found_o   (arb_found)
    );

    // A valid result that downstream refuses freezes the whole activation
    // pipeline, so the head word and its sideband stay put.
    assign RELU_EN    = !(RELU_Y_VLD && !OUT_RDY);
    assign in_grant   = (state_q == ST_GRANT);
    assign xfer       = in_grant && REQ_VLD[gnt_q] && RELU_EN;
    assign burst_end  = REQ_LAST[gnt_q] || (cnt_q == CNT_W'(BURST - 1));

    assign RELU_X     = in_grant ? req_word[gnt_q] : '0;
    assign RELU_X_VLD = xfer;

    always_comb begin
        REQ_RDY = '0;
        if (in_grant && RELU_EN) begin
            REQ_RDY[gnt_q] = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= ST_IDLE;
            ptr_q   <= CH_W'(NUM_CH - 1);
            gnt_q   <= '0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (arb_found) begin
                        gnt_q   <= arb_idx;
                        cnt_q   <= '0;
                        state_q <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (xfer) begin
                        if (burst_end) begin
                            ptr_q   <= gnt_q;
                            cnt_q   <= '0;
                            state_q <= ST_IDLE;
                        end else begin
                            cnt_q   <= cnt_q + 1'b1;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Sideband entering the pipeline alongside X. Flags are qualified with
    // the transfer so idle slots carry clean zeros.
    always_comb begin
        sb_d      = '0;
        sb_d.ch   = SB_CH_W'(gnt_q);
        sb_d.last = REQ_LAST[gnt_q] && xfer;
`ifdef RELU_SCHED_BYPASS_EN
        sb_d.byp  = REQ_BYP[gnt_q] && xfer;
`endif
        sb_d.vld  = xfer;
    end

    // Advances exactly when the activation unit does, keeping alignment.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < RELU_LAT; i++) begin
                sb_q[i] <= '0;
            end
        end else if (RELU_EN) begin
            sb_q[0] <= sb_d;
            for (int i = 1; i < RELU_LAT; i++) begin
                sb_q[i] <= sb_q[i-1];
            end
        end
    end

    assign sb_out   = sb_q[RELU_LAT-1];
    assign OUT_VLD  = RELU_Y_VLD;
    assign OUT_CH   = sb_out.ch[CH_W-1:0];
    assign OUT_LAST = sb_out.last;

`ifdef RELU_SCHED_BYPASS_EN
    assign OUT_DATA = sb_out.byp ? RELU_PASSTHRU : RELU_Y;
`else
    assign OUT_DATA = RELU_Y;
    logic unused_passthru;
    assign unused_passthru = ^RELU_PASSTHRU;
`endif

    logic unused_sb;
    assign unused_sb = ^{sb_out.ch, sb_out.vld};

    assign DRAINED  = !in_grant && !sb_q[0].vld && !RELU_Y_VLD;

endmodule : relu_sched
`default_nettype wire

// File: tb/tb_relu_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_relu_sched
// Purpose  : Self-checking bench for relu_sched. Models the activation unit,
//            drives per-channel word queues, predicts the grant order at the
//            burst level and checks every result against a per-channel
//            scoreboard. Build option RELU_SCHED_BYPASS_EN is honoured.
// Revision : 1.0 - initial release
// ============================================================================
module tb_relu_sched;

    localparam int NUM_CH  = 4;
    localparam int INWIDTH = 16;
    localparam int BURST   = 8;
    localparam int CH_W    = 2;

    logic                       CLK = 1'b0;
    logic                       RESET = 1'b1;
    logic [NUM_CH*INWIDTH-1:0]  REQ_DATA = '0;
    logic [NUM_CH-1:0]          REQ_VLD = '0;
    logic [NUM_CH-1:0]          REQ_LAST = '0;
`ifdef RELU_SCHED_BYPASS_EN
    logic [NUM_CH-1:0]          REQ_BYP = '0;
`endif
    logic [NUM_CH-1:0]          REQ_RDY;
    logic                       RELU_EN;
    logic [INWIDTH-1:0]         RELU_X;
    logic                       RELU_X_VLD;
    logic [INWIDTH-1:0]         RELU_Y;
    logic                       RELU_Y_VLD;
    logic [INWIDTH-1:0]         RELU_PASSTHRU;
    logic [INWIDTH-1:0]         OUT_DATA;
    logic                       OUT_VLD;
    logic                       OUT_RDY = 1'b1;
    logic [CH_W-1:0]            OUT_CH;
    logic                       OUT_LAST;
    logic                       DRAINED;

    always #5 CLK = ~CLK;

    relu_sched #(
        .NUM_CH  (NUM_CH),
        .INWIDTH (INWIDTH),
        .BURST   (BURST)
    ) dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .REQ_DATA      (REQ_DATA),
        .REQ_VLD       (REQ_VLD),
        .REQ_LAST      (REQ_LAST),
`ifdef RELU_SCHED_BYPASS_EN
        .REQ_BYP       (REQ_BYP),
`endif
        .REQ_RDY       (REQ_RDY),
        .RELU_EN       (RELU_EN),
        .RELU_X        (RELU_X),
        .RELU_X_VLD    (RELU_X_VLD),
        .RELU_Y        (RELU_Y),
        .RELU_Y_VLD    (RELU_Y_VLD),
        .RELU_PASSTHRU (RELU_PASSTHRU),
        .OUT_DATA      (OUT_DATA),
        .OUT_VLD       (OUT_VLD),
        .OUT_RDY       (OUT_RDY),
        .OUT_CH        (OUT_CH),
        .OUT_LAST      (OUT_LAST),
        .DRAINED       (DRAINED)
    );

    // Two-stage activation unit: stalls on !EN, rectifies signed X.
    logic [INWIDTH-1:0] a1_x, a2_x;
    logic               a1_v, a2_v;
    always @(posedge CLK) begin
        if (RESET) begin
            a1_v <= 1'b0; a2_v <= 1'b0; a1_x <= '0; a2_x <= '0;
        end else if (RELU_EN) begin
            a1_v <= RELU_X_VLD; a1_x <= RELU_X;
            a2_v <= a1_v;       a2_x <= a1_x;
        end
    end
    assign RELU_Y_VLD    = a2_v;
    assign RELU_Y        = ($signed(a2_x) < 0) ? '0 : a2_x;
    assign RELU_PASSTHRU = a2_x;

    // Word = {byp, last, data}; expected = {last, out_data}.
    logic [17:0] src_q [NUM_CH][$];
    logic [16:0] exp_q [NUM_CH][$];
    int          sched[$];
    bit          sched_new[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0, phase_cyc = 0, acc_idx = 0, last_acc_cyc = 0;
    int first_acc_cyc = -1, first_out_cyc = -1;
    int rdy_mode = 0;
    bit hold_pend = 1'b0;
    logic [31:0] held = '0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] relu_ref(input logic [15:0] x);
        return ($signed(x) < 0) ? 16'h0 : x;
    endfunction

    task automatic push_word(input int ch, input logic [15:0] d, input bit last, input bit byp);
`ifdef RELU_SCHED_BYPASS_EN
        src_q[ch].push_back({byp, last, d});
`else
        src_q[ch].push_back({1'b0 & byp, last, d});
`endif
    endtask

    // Expected order of accepted words: every requester holds VLD while it
    // has words, so each grant goes to the next non-empty channel after the
    // previous one and lasts until LAST or BURST words.
    task automatic build_sched(input int start_ptr);
        int pos [NUM_CH];
        int p, ch, n, c;
        bit lst;
        sched.delete();
        sched_new.delete();
        for (int i = 0; i < NUM_CH; i++) pos[i] = 0;
        p = start_ptr;
        while (1) begin
            ch = -1;
            for (int k = 1; k <= NUM_CH; k++) begin
                c = (p + k) % NUM_CH;
                if (ch < 0 && pos[c] < src_q[c].size()) ch = c;
            end
            if (ch < 0) break;
            n = 0;
            lst = 1'b0;
            while (!lst && n < BURST && pos[ch] < src_q[ch].size()) begin
                sched.push_back(ch);
                sched_new.push_back(n == 0);
                lst = src_q[ch][pos[ch]][16];
                pos[ch]++;
                n++;
            end
            p = ch;
        end
    endtask

    task automatic drive();
        logic [17:0] w;
        for (int i = 0; i < NUM_CH; i++) begin
            w = (src_q[i].size() > 0) ? src_q[i][0] : 18'h0;
            REQ_VLD[i] = (src_q[i].size() > 0);
            REQ_DATA[i*INWIDTH +: INWIDTH] = w[15:0];
            REQ_LAST[i] = w[16];
`ifdef RELU_SCHED_BYPASS_EN
            REQ_BYP[i] = w[17];
`endif
        end
        case (rdy_mode)
            0:       OUT_RDY = 1'b1;
            1:       OUT_RDY = ($urandom_range(0, 99) < 70);
            default: OUT_RDY = !(phase_cyc >= 6 && phase_cyc < 9);
        endcase
    endtask

    task automatic step();
        logic [NUM_CH-1:0] acc;
        logic [17:0]       w;
        logic [16:0]       e;
        @(negedge CLK);
        cyc++;
        phase_cyc++;
        acc = '0;
        if (hold_pend) chk("hold", {12'h0, OUT_VLD, OUT_LAST, OUT_CH, OUT_DATA}, held);
        hold_pend = 1'b0;
        if (OUT_VLD && !OUT_RDY) begin
            chk("rdy_in_stall", {28'h0, REQ_RDY}, 32'h0);
            hold_pend = 1'b1;
            held = {12'h0, OUT_VLD, OUT_LAST, OUT_CH, OUT_DATA};
        end
        if (OUT_VLD && OUT_RDY) begin
            if (first_out_cyc < 0) first_out_cyc = cyc;
            if (exp_q[OUT_CH].size() == 0) begin
                chk("spurious_out", {30'h0, OUT_CH}, 32'hFFFF_FFFF);
            end else begin
                e = exp_q[OUT_CH].pop_front();
                chk("out_word", {15'h0, OUT_LAST, OUT_DATA}, {15'h0, e});
            end
        end
        for (int i = 0; i < NUM_CH; i++) begin
            if (REQ_VLD[i] && REQ_RDY[i]) begin
                acc[i] = 1'b1;
                w = src_q[i][0];
                if (acc_idx >= sched.size()) begin
                    chk("sched_overrun", acc_idx, sched.size());
                end else begin
                    chk("sched_ch", i, sched[acc_idx]);
                    if (sched_new[acc_idx] && acc_idx > 0)
                        chk("bubble", {31'h0, (cyc - last_acc_cyc) >= 2}, 32'h1);
                end
                chk("relu_x", {15'h0, RELU_X_VLD, RELU_X}, {15'h0, 1'b1, w[15:0]});
                exp_q[i].push_back({w[16], w[17] ? w[15:0] : relu_ref(w[15:0])});
                acc_idx++;
                last_acc_cyc = cyc;
                if (first_acc_cyc < 0) first_acc_cyc = cyc;
            end
        end
        @(posedge CLK);
        #1;
        for (int i = 0; i < NUM_CH; i++) if (acc[i]) void'(src_q[i].pop_front());
        drive();
    endtask

    task automatic clear_queues();
        for (int i = 0; i < NUM_CH; i++) begin
            src_q[i].delete();
            exp_q[i].delete();
        end
        hold_pend = 1'b0;
    endtask

    task automatic do_reset(input bit check);
        RESET = 1'b1;
        clear_queues();
        drive();
        repeat (2) @(posedge CLK);
        #1;
        RESET = 1'b0;
        @(negedge CLK);
        if (check) begin
            chk("rst_req_rdy", {28'h0, REQ_RDY}, 32'h0);
            chk("rst_x_vld", {31'h0, RELU_X_VLD}, 32'h0);
            chk("rst_relu_en", {31'h0, RELU_EN}, 32'h1);
            chk("rst_out", {28'h0, OUT_VLD, OUT_LAST, OUT_CH}, 32'h0);
            chk("rst_drained", {31'h0, DRAINED}, 32'h1);
        end
        @(posedge CLK);
        #1;
    endtask

    function automatic bit phase_done();
        for (int i = 0; i < NUM_CH; i++)
            if (src_q[i].size() != 0 || exp_q[i].size() != 0) return 1'b0;
        return DRAINED;
    endfunction

    task automatic start_phase();
        acc_idx = 0;
        phase_cyc = 0;
        first_acc_cyc = -1;
        first_out_cyc = -1;
        build_sched(NUM_CH - 1);
        drive();
    endtask

    task automatic run_phase(input int budget);
        int n;
        bit done;
        n = 0;
        done = 1'b0;
        start_phase();
        while (!done && n < budget) begin
            step();
            n++;
            done = phase_done();
        end
        if (!done) chk("timeout", 32'h0, 32'h1);
        chk("sched_len", acc_idx, sched.size());
    endtask

    initial begin
        // Reset values and single channel: -5, 0, 7(LAST) -> 0, 0, 7.
        do_reset(1'b1);
        rdy_mode = 0;
        push_word(0, 16'hFFFB, 1'b0, 1'b0);
        push_word(0, 16'h0000, 1'b0, 1'b0);
        push_word(0, 16'h0007, 1'b1, 1'b0);
        run_phase(100);
        chk("latency", first_out_cyc - first_acc_cyc, 2);

        // Contention: ch0 and ch1 with 20 words each, LAST only at the end.
        do_reset(1'b0);
        for (int j = 0; j < 20; j++) begin
            push_word(0, 16'(j * 3 + 1), j == 19, 1'b0);
            push_word(1, 16'(16'h8000 + j), j == 19, 1'b0);
        end
        run_phase(400);

        // Early release: ch2 sends 3 words, ch3 pending.
        do_reset(1'b0);
        for (int j = 0; j < 3; j++) push_word(2, 16'(100 + j), j == 2, 1'b0);
        for (int j = 0; j < 5; j++) push_word(3, 16'(200 + j), j == 4, 1'b0);
        run_phase(200);

        // Backpressure window mid-burst.
        do_reset(1'b0);
        rdy_mode = 2;
        for (int j = 0; j < 12; j++) push_word(0, 16'($urandom), j == 11, 1'b0);
        for (int j = 0; j < 5; j++) push_word(3, 16'($urandom), j == 4, 1'b0);
        run_phase(200);

`ifdef RELU_SCHED_BYPASS_EN
        // Bypass: -9 raw, then -9 rectified.
        do_reset(1'b0);
        rdy_mode = 0;
        push_word(0, 16'hFFF7, 1'b0, 1'b1);
        push_word(0, 16'hFFF7, 1'b1, 1'b0);
        run_phase(100);
`endif

        // Randomized traffic with random downstream readiness.
        rdy_mode = 1;
        for (int r = 0; r < 4; r++) begin
            int len;
            do_reset(1'b0);
            for (int i = 0; i < NUM_CH; i++) begin
                len = $urandom_range(0, 20);
                for (int j = 0; j < len; j++)
                    push_word(i, 16'($urandom), (j == len - 1) || ($urandom_range(0, 5) == 0),
                              1'($urandom_range(0, 1)));
            end
            run_phase(3000);
        end

        // Reset mid-burst with words in flight, then ch0 must win.
        do_reset(1'b0);
        rdy_mode = 0;
        for (int j = 0; j < 10; j++) push_word(1, 16'(j + 1), j == 9, 1'b0);
        start_phase();
        for (int n = 0; n < 50 && acc_idx < 3; n++) step();
        chk("pre_reset_accepts", acc_idx, 3);
        RESET = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        chk("mid_rst_out_vld", {31'h0, OUT_VLD}, 32'h0);
        chk("mid_rst_drained", {31'h0, DRAINED}, 32'h1);
        clear_queues();
        drive();
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        push_word(1, 16'h0011, 1'b1, 1'b0);
        push_word(0, 16'h0022, 1'b1, 1'b0);
        run_phase(100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_relu_sched
`default_nettype wire
